// File: rtl/ddr_init_seq.sv
// ddr_init_seq: DDR3 power-up / initialisation sequencer.
// Walks the DRAM through reset, CKE enable, MR2/MR3/MR1/MR0 programming and
// ZQ calibration on the DFI command bus, then raises a sticky done flag.
// Every DFI output is a register fed from the current state, so the bus lags
// the state by one cycle and never glitches.
module ddr_init_seq #(
  parameter int T_RESET  = 200,
  parameter int T_CKE    = 500,
  parameter int T_XPR    = 60,
  parameter int T_MRD    = 4,
  parameter int T_MOD    = 12,
  parameter int T_ZQINIT = 512,
  parameter int ADDR_W   = 14,
  parameter int BANK_W   = 3
) (
  input  logic              core_clk,
  input  logic              core_arstn,
  input  logic              ddr_init_start,
  output logic              ddr_init_done,
  input  logic [ADDR_W-1:0] mr0,
  input  logic [ADDR_W-1:0] mr1,
  input  logic [ADDR_W-1:0] mr2,
  input  logic [ADDR_W-1:0] mr3,
  output logic              dfi_reset_n,
  output logic              dfi_cke,
  output logic              dfi_cs_n,
  output logic              dfi_ras_n,
  output logic              dfi_cas_n,
  output logic              dfi_we_n,
  output logic [ADDR_W-1:0] dfi_address,
  output logic [BANK_W-1:0] dfi_bank
);

  localparam int CNT_W = 20;

  // Counter load values: a timed state of N cycles starts at N-1 and exits at 0.
  localparam logic [CNT_W-1:0] LD_RESET  = CNT_W'(T_RESET - 1);
  localparam logic [CNT_W-1:0] LD_CKE    = CNT_W'(T_CKE - 1);
  localparam logic [CNT_W-1:0] LD_XPR    = CNT_W'(T_XPR - 1);
  localparam logic [CNT_W-1:0] LD_MRD    = CNT_W'(T_MRD - 1);
  localparam logic [CNT_W-1:0] LD_MOD    = CNT_W'(T_MOD - 1);
  localparam logic [CNT_W-1:0] LD_ZQINIT = CNT_W'(T_ZQINIT - 1);

  // ZQCL long calibration: A10 high, all other address bits low.
  localparam logic [ADDR_W-1:0] ZQCL_ADDR = ADDR_W'(11'h400);

  // Command encodings as {cs_n, ras_n, cas_n, we_n}.
  localparam logic [3:0] CMD_DES  = 4'b1111;
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RST_HOLD,
    S_CKE_WAIT,
    S_XPR,
    S_MRS,
    S_WAIT,
    S_ZQCL,
    S_ZQWAIT,
    S_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [1:0]         idx_q;
  logic [1:0]         idx_d;
  logic               capture;
  logic [ADDR_W-1:0]  mr_cap [4];

  logic               done_nxt;
  logic               reset_n_nxt;
  logic               cke_nxt;
  logic [3:0]         cmd_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [1:0]         bank_nxt;

  // Position in the MRS sequence -> mode register number (MR2, MR3, MR1, MR0).
  function automatic logic [1:0] mr_of_idx(input logic [1:0] idx);
    logic [1:0] mr;
    case (idx)
      2'd0:    mr = 2'd2;
      2'd1:    mr = 2'd3;
      2'd2:    mr = 2'd1;
      default: mr = 2'd0;
    endcase
    return mr;
  endfunction

  // State, counter and MRS position registers.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Mode register snapshot taken as the sequence leaves IDLE; inputs are
  // ignored afterwards so the parent may change them freely.
  always_ff @(posedge core_clk) begin
    if (capture) begin
      mr_cap[0] <= mr0;
      mr_cap[1] <= mr1;
      mr_cap[2] <= mr2;
      mr_cap[3] <= mr3;
    end
  end

  // Next-state logic: each timed state reloads the counter on entry and
  // leaves on the cycle it reads zero.
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ddr_init_start) begin
          state_d = S_RST_HOLD;
          cnt_d   = LD_RESET;
          idx_d   = 2'd0;
          capture = 1'b1;
        end
      end
      S_RST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_CKE_WAIT;
          cnt_d   = LD_CKE;
        end
      end
      S_CKE_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_XPR;
          cnt_d   = LD_XPR;
        end
      end
      S_XPR: begin
        if (cnt_q == '0) begin
          state_d = S_MRS;
          cnt_d   = '0;
        end
      end
      S_MRS: begin
        // MR0 is last and needs tMOD before the next command; others need tMRD.
        state_d = S_WAIT;
        cnt_d   = (idx_q == 2'd3) ? LD_MOD : LD_MRD;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d = S_ZQCL;
          end else begin
            state_d = S_MRS;
            idx_d   = idx_q + 2'd1;
          end
        end
      end
      S_ZQCL: begin
        state_d = S_ZQWAIT;
        cnt_d   = LD_ZQINIT;
      end
      S_ZQWAIT: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // DFI bus contents implied by the current state.
  always_comb begin
    done_nxt    = 1'b0;
    reset_n_nxt = 1'b1;
    cke_nxt     = 1'b1;
    cmd_nxt     = CMD_NOP;
    addr_nxt    = '0;
    bank_nxt    = '0;
    case (state_q)
      S_IDLE, S_RST_HOLD: begin
        reset_n_nxt = 1'b0;
        cke_nxt     = 1'b0;
        cmd_nxt     = CMD_DES;
      end
      S_CKE_WAIT: begin
        cke_nxt = 1'b0;
        cmd_nxt = CMD_DES;
      end
      S_MRS: begin
        cmd_nxt  = CMD_MRS;
        bank_nxt = mr_of_idx(idx_q);
        addr_nxt = mr_cap[mr_of_idx(idx_q)];
      end
      S_ZQCL: begin
        cmd_nxt  = CMD_ZQCL;
        addr_nxt = ZQCL_ADDR;
      end
      S_DONE: begin
        done_nxt = 1'b1;
      end
      default: begin
        cmd_nxt = CMD_NOP;
      end
    endcase
  end

  // Output registers; reset puts the bus in DES with the DRAM held in reset.
  always_ff @(posedge core_clk or negedge core_arstn) begin
    if (!core_arstn) begin
      ddr_init_done <= 1'b0;
      dfi_reset_n   <= 1'b0;
      dfi_cke       <= 1'b0;
      dfi_cs_n      <= 1'b1;
      dfi_ras_n     <= 1'b1;
      dfi_cas_n     <= 1'b1;
      dfi_we_n      <= 1'b1;
      dfi_address   <= '0;
      dfi_bank      <= '0;
    end else begin
      ddr_init_done <= done_nxt;
      dfi_reset_n   <= reset_n_nxt;
      dfi_cke       <= cke_nxt;
      dfi_cs_n      <= cmd_nxt[3];
      dfi_ras_n     <= cmd_nxt[2];
      dfi_cas_n     <= cmd_nxt[1];
      dfi_we_n      <= cmd_nxt[0];
      dfi_address   <= addr_nxt;
      dfi_bank      <= BANK_W'(bank_nxt);
    end
  end

endmodule

// File: doc/ddr_init_seq.md
Name: ddr_init_seq

Overview:
- JESD79-3 DDR3 power-up/initialisation sequencer.
- Sits directly downstream of the main controller FSM. It consumes that FSM's `ddr_init_start` level and returns `ddr_init_done`.
- Drives the DFI command/control bus during initialisation: reset, CKE, MRS to MR2/MR3/MR1/MR0, then ZQCL.
- The main controller owns the DFI bus once `ddr_init_done` is high; the muxing lives in the parent.

Parameters:
- T_RESET, 200, cycles `dfi_reset_n` held low (tRESET, scaled).
- T_CKE, 500, cycles after reset release with CKE low.
- T_XPR, 60, NOP cycles after CKE high before first MRS (tXPR).
- T_MRD, 4, NOP cycles after MR2/MR3/MR1 MRS (tMRD).
- T_MOD, 12, NOP cycles after MR0 MRS (tMOD).
- T_ZQINIT, 512, NOP cycles after ZQCL (tZQinit).
- ADDR_W, 14, DFI address width.
- BANK_W, 3, DFI bank width.
- All T_* values are ≥1 and ≤2^20−1.

Ports:
- core_clk  in  1  core clock
- core_arstn  in  1  async reset, active-low
- ddr_init_start  in  1  level request from main controller
- ddr_init_done  out  1  sequence complete, sticky
- mr0  in  ADDR_W  MR0 value
- mr1  in  ADDR_W  MR1 value
- mr2  in  ADDR_W  MR2 value
- mr3  in  ADDR_W  MR3 value
- dfi_reset_n  out  1  DRAM reset
- dfi_cke  out  1  clock enable
- dfi_cs_n  out  1  chip select
- dfi_ras_n  out  1  RAS
- dfi_cas_n  out  1  CAS
- dfi_we_n  out  1  WE
- dfi_address  out  ADDR_W  address
- dfi_bank  out  BANK_W  bank

Behaviour:
- Clocking/reset:
  - Single clock domain; all outputs registered.
  - Async reset forces: state IDLE, counter 0, `ddr_init_done`=0, `dfi_reset_n`=0, `dfi_cke`=0, `dfi_cs_n`/`ras_n`/`cas_n`/`we_n`=1 (DES), `dfi_address`=0, `dfi_bank`=0.
- Start:
  - `mr0..mr3` are captured into internal registers on the edge that leaves IDLE. Later changes are ignored.
- States and transitions:
  - IDLE: outputs at reset values. `ddr_init_start`=1 → RST_HOLD.
  - RST_HOLD: `reset_n`=0, `cke`=0, DES, for T_RESET cycles → CKE_WAIT.
  - CKE_WAIT: `reset_n`=1, `cke`=0, DES, for T_CKE cycles → XPR.
  - XPR: `cke`=1, NOP (cs=0, ras=cas=we=1), for T_XPR cycles → MRS.
  - MRS: one cycle with cs/ras/cas/we all 0, `bank`=MR index, `address`=captured MR value → WAIT.
    - Order is MR2, MR3, MR1, MR0; a 2-bit index tracks position.
  - WAIT (NOP) after an MRS:
    - After MR2/MR3/MR1: T_MRD cycles → next MRS.
    - After MR0: T_MOD cycles → ZQCL.
  - ZQCL: one cycle with cs=0, ras=1, cas=1, we=0, `address[10]`=1, other address bits 0, `bank`=0 → ZQWAIT.
  - ZQWAIT: NOP for T_ZQINIT cycles → DONE.
  - DONE: `ddr_init_done`=1, NOP, `cke`=1, `reset_n`=1. Terminal until reset.
- Counter:
  - One 20-bit down-counter, loaded with N−1 on state entry.
  - Transition occurs on the cycle the counter reads 0, so each timed state lasts exactly N cycles.
- Latency:
  - `ddr_init_done` rises exactly T_RESET+T_CKE+T_XPR+3·(T_MRD+1)+(T_MOD+1)+(T_ZQINIT+1)+1 cycles after the edge that samples `ddr_init_start`=1 in IDLE.
- Boundary conditions:
  - `ddr_init_start` deasserting mid-sequence is ignored; the sequence runs to completion.
  - `ddr_init_start` held high in DONE causes no restart.
  - Start is asserted in the same cycle reset releases: first sampled on the first edge after release.
  - Reset mid-sequence: immediate return to IDLE with reset output values; restarts only on a new start.
  - Commands (MRS/ZQCL) are asserted for exactly one cycle, never back-to-back.

Test Plan:
- Params T_RESET=8, T_CKE=10, T_XPR=5, T_MRD=4, T_MOD=12, T_ZQINIT=16; start pulse held → `dfi_reset_n` low 8 cycles, `cke` rises 10 cycles after `reset_n`, `ddr_init_done` rises 69 cycles after start sample, stays high.
- mr2=0x0008, mr3=0x0000, mr1=0x0044, mr0=0x1520 → exactly four MRS cycles in order:
  - bank=2 addr=0x0008
  - bank=3 addr=0x0000
  - bank=1 addr=0x0044
  - bank=0 addr=0x1520
  - Spacing: 5 cycles between MR2→MR3→MR1→MR0 issue; MR0→ZQCL spacing 13 cycles.
- ZQCL check → single cycle cs=0, ras=1, cas=1, we=0, address=0x0400; `done` 17 cycles later.
- Change mr0..mr3 and drop `ddr_init_start` after 3 cycles → MRS payloads equal the values captured at start; sequence completes normally.
- Assert `core_arstn`=0 during WAIT after MR3 → outputs immediately at reset values, `done`=0; restart yields full sequence from RST_HOLD.
- Hold start high after DONE for 100 cycles → no further MRS/ZQCL, `done` stays 1, bus stays NOP with `cke`=1.
